// File: rtl/sync_bus_arbiter.sv
// sync_bus_arbiter
// Source-domain front end for a shared multi-bit CDC synchronizer channel.
// Picks one requester, captures its word onto unsync_bus, and frames it with
// a bus_enable pulse of HOLD_CYCLES followed by at least GAP_CYCLES+1 low
// cycles. The destination side therefore sees exactly one clean enable edge
// around a bus that does not move.
//
// Build option: define SYNC_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no last-grant pointer). The default build is round-robin.
module sync_bus_arbiter #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic [ID_WIDTH-1:0]          src_id,
    output logic                         busy
);

    // The counter only ever holds a load value minus one, so it needs
    // enough bits for max(HOLD_CYCLES, GAP_CYCLES) - 1.
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [ID_WIDTH-1:0]  winner;
    logic [NUM_REQ-1:0]   winner_onehot;
    logic [BUS_WIDTH-1:0] winner_word;
    logic                 any_req;

    assign any_req = |req;
    assign busy    = (state != IDLE);

`ifdef SYNC_ARB_FIXED_PRIO_EN

    // Fixed priority: scanning from the top down leaves the lowest index set.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = ID_WIDTH'(i);
            end
        end
    end

`else

    logic [ID_WIDTH-1:0] last;

    // Round-robin: search starts just after the last granted index and wraps.
    always_comb begin : rr_search
        int                  idx_int;
        logic [ID_WIDTH-1:0] idx;
        logic                found;
        winner  = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_int = (int'(last) + i) % NUM_REQ;
            idx     = ID_WIDTH'(idx_int);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`endif

    // Decode the chosen index into the grant pattern and the word to capture.
    always_comb begin
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
        winner_word           = req_data[int'(winner) * BUS_WIDTH +: BUS_WIDTH];
    end

    // Transfer sequencer: accept in IDLE, hold enable high, then force a gap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= '0;
            unsync_bus <= '0;
            src_id     <= '0;
            bus_enable <= 1'b0;
`ifndef SYNC_ARB_FIXED_PRIO_EN
            last       <= ID_WIDTH'(NUM_REQ - 1);
`endif
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        unsync_bus <= winner_word;
                        src_id     <= winner;
                        grant      <= winner_onehot;
                        bus_enable <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= HOLD;
`ifndef SYNC_ARB_FIXED_PRIO_EN
                        last       <= winner;
`endif
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        bus_enable <= 1'b0;
                        cnt        <= GAP_LOAD;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    bus_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// tb_sync_bus_arbiter
// Bench for sync_bus_arbiter. The reference model tracks how many cycles have
// passed since the last acceptance and derives every output from that count.
module tb_sync_bus_arbiter;

    localparam int BW  = 8;
    localparam int NR  = 4;
    localparam int H   = 4;
    localparam int G   = 2;
    localparam int IDW = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*BW-1:0]  req_data = '0;
    logic [NR-1:0]     grant;
    logic [BW-1:0]     unsync_bus;
    logic              bus_enable;
    logic [IDW-1:0]    src_id;
    logic              busy;

    logic [1:0]        req2 = '0;
    logic [15:0]       req_data2 = '0;
    logic [1:0]        grant2;
    logic [7:0]        bus2;
    logic              en2;
    logic [0:0]        id2;
    logic              busy2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int            m_k;
    int            m_last;
    int            m_id;
    logic [BW-1:0] m_bus;
    logic [NR-1:0] m_grant;

    sync_bus_arbiter #(
        .BUS_WIDTH(BW), .NUM_REQ(NR), .HOLD_CYCLES(H), .GAP_CYCLES(G), .ID_WIDTH(IDW)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .grant(grant),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable), .src_id(src_id), .busy(busy)
    );

    sync_bus_arbiter #(
        .BUS_WIDTH(8), .NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(1), .ID_WIDTH(1)
    ) dut2 (
        .CLK(CLK), .RST(RST), .req(req2), .req_data(req_data2), .grant(grant2),
        .unsync_bus(bus2), .bus_enable(en2), .src_id(id2), .busy(busy2)
    );

    // Free-running source clock
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Arbitration rule straight from the description: the lowest requesting
    // index above last, otherwise the lowest requesting index overall.
    function automatic int pick(input logic [NR-1:0] r, input int last);
        int p;
        p = -1;
`ifdef SYNC_ARB_FIXED_PRIO_EN
        for (int i = NR - 1; i >= 0; i--) if (r[i]) p = i;
`else
        for (int i = NR - 1; i > last; i--) if (r[i]) p = i;
        if (p < 0) begin
            for (int i = last; i >= 0; i--) if (r[i]) p = i;
        end
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_k     = H + G;
        m_last  = NR - 1;
        m_id    = 0;
        m_bus   = '0;
        m_grant = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic tick(input logic [NR-1:0] r, input logic [NR*BW-1:0] d);
        int w;
        req      = r;
        req_data = d;
        @(posedge CLK);
        if (m_k >= H + G && r != '0) begin
            w       = pick(r, m_last);
            m_bus   = d[w*BW +: BW];
            m_id    = w;
            m_grant = NR'(1) << w;
            m_last  = w;
            m_k     = 0;
        end else begin
            m_grant = '0;
            if (m_k < H + G) m_k++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_k < H + G; i++) tick('0, '0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        req = '0;
        req_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (grant !== '0) begin n_fail++; $display("[TB] FAIL reset_grant: got %0h want 0", grant); end
        n_cmp++; if (unsync_bus !== '0) begin n_fail++; $display("[TB] FAIL reset_bus: got %0h want 0", unsync_bus); end
        n_cmp++; if (src_id !== '0) begin n_fail++; $display("[TB] FAIL reset_src_id: got %0h want 0", src_id); end
        n_cmp++; if (bus_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_enable: got %0b want 0", bus_enable); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (grant2 !== '0 || en2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dut2: got %0h/%0b want 0/0", grant2, en2); end
        #2 RST = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [NR*BW-1:0] d;
        d = {$urandom};
        d[2*BW +: BW] = 8'hA5;
        tick(4'b0100, d);
        n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_grant: got %0h want 4", grant); end
        n_cmp++; if (unsync_bus !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_bus: got %0h want a5", unsync_bus); end
        n_cmp++; if (src_id !== 2'd2) begin n_fail++; $display("[TB] FAIL single_src_id: got %0h want 2", src_id); end
        n_cmp++; if (bus_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL single_enable0: got %0b want 1", bus_enable); end
        for (int c = 1; c <= 6; c++) begin
            tick('0, {$urandom});
            n_cmp++; if (bus_enable !== (c < H)) begin n_fail++; $display("[TB] FAIL single_enable%0d: got %0b want %0b", c, bus_enable, (c < H)); end
            n_cmp++; if (busy !== (c < H + G)) begin n_fail++; $display("[TB] FAIL single_busy%0d: got %0b want %0b", c, busy, (c < H + G)); end
            n_cmp++; if (unsync_bus !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_hold_bus%0d: got %0h want a5", c, unsync_bus); end
        end
    endtask

    task automatic test_round_robin();
        int idx_q[$];
        int cyc_q[$];
        int exp_idx;
        RST = 1'b1;
        #2 RST = 1'b0;
        model_reset();
        for (int c = 0; c < 29; c++) begin
            tick(4'hF, {$urandom});
            if (grant != '0) begin
                for (int b = 0; b < NR; b++) if (grant[b]) idx_q.push_back(b);
                cyc_q.push_back(c);
            end
        end
        n_cmp++; if (idx_q.size() != 5) begin n_fail++; $display("[TB] FAIL rr_count: got %0d want 5", idx_q.size()); end
        for (int i = 0; i < idx_q.size() && i < 5; i++) begin
`ifdef SYNC_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % NR;
`endif
            n_cmp++; if (idx_q[i] != exp_idx) begin n_fail++; $display("[TB] FAIL rr_order%0d: got %0d want %0d", i, idx_q[i], exp_idx); end
            if (i > 0 && i < cyc_q.size()) begin
                n_cmp++; if (cyc_q[i] - cyc_q[i-1] != 7) begin n_fail++; $display("[TB] FAIL rr_spacing%0d: got %0d want 7", i, cyc_q[i] - cyc_q[i-1]); end
            end
        end
    endtask

    task automatic test_hold_request();
        logic [NR*BW-1:0] d0;
        logic [NR*BW-1:0] d1;
        drain();
        d0 = {$urandom};
        d0[0 +: BW] = 8'h5C;
        d1 = {$urandom};
        d1[0 +: BW] = 8'hEE;
        d1[BW +: BW] = 8'h77;
        tick(4'b0001, d0);
        n_cmp++; if (grant !== 4'b0001 || unsync_bus !== 8'h5C) begin n_fail++; $display("[TB] FAIL hold_first: got %0h/%0h want 1/5c", grant, unsync_bus); end
        for (int c = 1; c <= 6; c++) begin
            tick(4'b0010, d1);
            n_cmp++; if (grant !== '0) begin n_fail++; $display("[TB] FAIL hold_nogrant%0d: got %0h want 0", c, grant); end
            n_cmp++; if (unsync_bus !== 8'h5C || src_id !== 2'd0) begin n_fail++; $display("[TB] FAIL hold_stable%0d: got %0h/%0h want 5c/0", c, unsync_bus, src_id); end
        end
        tick(4'b0010, d1);
        n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL hold_late_grant: got %0h want 2", grant); end
        n_cmp++; if (unsync_bus !== 8'h77 || src_id !== 2'd1) begin n_fail++; $display("[TB] FAIL hold_late_word: got %0h/%0h want 77/1", unsync_bus, src_id); end
    endtask

    task automatic test_back_to_back();
        logic [NR*BW-1:0] d;
        int second;
        int low;
        second = -1;
        low = 0;
        drain();
        d = {$urandom};
        d[3*BW +: BW] = 8'h11;
        tick(4'b1000, d);
        n_cmp++; if (grant !== 4'b1000 || unsync_bus !== 8'h11) begin n_fail++; $display("[TB] FAIL b2b_first: got %0h/%0h want 8/11", grant, unsync_bus); end
        d[3*BW +: BW] = 8'h22;
        for (int c = 1; c <= 12 && second < 0; c++) begin
            tick(4'b1000, d);
            if (bus_enable === 1'b0) low++;
            if (grant != '0) second = c;
        end
        n_cmp++; if (second != 7) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d want 7", second); end
        n_cmp++; if (low != 3) begin n_fail++; $display("[TB] FAIL b2b_low_cycles: got %0d want 3", low); end
        n_cmp++; if (grant !== 4'b1000 || unsync_bus !== 8'h22) begin n_fail++; $display("[TB] FAIL b2b_second: got %0h/%0h want 8/22", grant, unsync_bus); end
        tick('0, '0);
    endtask

    task automatic test_reset_mid_hold();
        logic [NR*BW-1:0] d;
        drain();
        d = {$urandom};
        tick(4'b0100, d);
        tick('0, d);
        n_cmp++; if (bus_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre: got %0b want 1", bus_enable); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (bus_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_enable: got %0b want 0", bus_enable); end
        n_cmp++; if (grant !== '0 || unsync_bus !== '0 || src_id !== '0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_outputs: got %0h/%0h/%0h/%0b want 0/0/0/0", grant, unsync_bus, src_id, busy);
        end
        #1 RST = 1'b0;
        model_reset();
        tick(4'hF, {$urandom});
        n_cmp++; if (grant !== 4'b0001 || src_id !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_next: got %0h/%0h want 1/0", grant, src_id); end
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, 15));
            tick(r, {$urandom});
            n_cmp++; if (grant !== m_grant) begin n_fail++; $display("[TB] FAIL rand_grant@%0d: got %0h want %0h", c, grant, m_grant); end
            n_cmp++; if (unsync_bus !== m_bus) begin n_fail++; $display("[TB] FAIL rand_bus@%0d: got %0h want %0h", c, unsync_bus, m_bus); end
            n_cmp++; if (src_id !== IDW'(m_id)) begin n_fail++; $display("[TB] FAIL rand_src_id@%0d: got %0h want %0h", c, src_id, m_id); end
            n_cmp++; if (bus_enable !== (m_k < H)) begin n_fail++; $display("[TB] FAIL rand_enable@%0d: got %0b want %0b", c, bus_enable, (m_k < H)); end
            n_cmp++; if (busy !== (m_k < H + G)) begin n_fail++; $display("[TB] FAIL rand_busy@%0d: got %0b want %0b", c, busy, (m_k < H + G)); end
            n_cmp++; if (!$onehot0(grant)) begin n_fail++; $display("[TB] FAIL rand_onehot@%0d: got %0h want one-hot", c, grant); end
        end
    endtask

    task automatic test_param_sweep();
        int   exp_idx;
        logic [1:0] exp_g;
        logic prev_en;
        prev_en = 1'b0;
        req = '0;
        req_data = '0;
        RST = 1'b1;
        req2 = 2'b11;
        req_data2 = {8'hB2, 8'hB1};
        #2 RST = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK);
            #1;
`ifdef SYNC_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = (c / 3) % 2;
`endif
            exp_g = (c % 3 == 0) ? (2'b01 << exp_idx) : 2'b00;
            n_cmp++; if (grant2 !== exp_g) begin n_fail++; $display("[TB] FAIL sweep_grant%0d: got %0h want %0h", c, grant2, exp_g); end
            n_cmp++; if (en2 !== (c % 3 == 0)) begin n_fail++; $display("[TB] FAIL sweep_enable%0d: got %0b want %0b", c, en2, (c % 3 == 0)); end
            n_cmp++; if (prev_en && en2) begin n_fail++; $display("[TB] FAIL sweep_gap%0d: got 1 want 0", c); end
            if (c % 3 == 0) begin
                n_cmp++; if (bus2 !== (exp_idx == 0 ? 8'hB1 : 8'hB2) || id2 !== 1'(exp_idx)) begin
                    n_fail++; $display("[TB] FAIL sweep_word%0d: got %0h/%0h want idx %0d", c, bus2, id2, exp_idx);
                end
            end
            prev_en = en2;
        end
        req2 = '0;
    endtask

    // Scenario sequence and summary
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_request();
        test_back_to_back();
        test_reset_mid_hold();
        test_random();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
